// File: rtl/mips_decode_queue_pkg.sv
// Shared definitions for the MIPS decode queue.
// Holds the opcode/funct codes, the ALU operation and second-operand
// encodings, and the packed layout of one decoded FIFO entry.
package mips_decode_queue_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  // R-type funct codes (inst[5:0]) under OP_OTHER0
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_NOR = 6'h27;
  localparam logic [5:0] OP0_XOR = 6'h26;

  // ALU operation encodings
  localparam logic [2:0] ALU_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_OP_ADD  = 3'b010;
  localparam logic [2:0] ALU_OP_SUB  = 3'b011;
  localparam logic [2:0] ALU_OP_AND  = 3'b100;
  localparam logic [2:0] ALU_OP_OR   = 3'b101;
  localparam logic [2:0] ALU_OP_NOR  = 3'b110;
  localparam logic [2:0] ALU_OP_XOR  = 3'b111;

  // Second ALU operand select encodings
  localparam logic [1:0] ALU_SRC2_RT   = 2'b00;
  localparam logic [1:0] ALU_SRC2_SEXT = 2'b01;
  localparam logic [1:0] ALU_SRC2_ZEXT = 2'b10;

  // One decoded instruction as stored in the FIFO
  typedef struct packed {
    logic        rd_src;
    logic        writeenable;
    logic [1:0]  alu_src2;
    logic [2:0]  alu_op;
    logic        except;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } entry_t;

endpackage

// File: rtl/mips_decode_queue_decode.sv
// Combinational MIPS control decoder.
// Ports: opcode/funct in; rd_src, writeenable, alu_src2, alu_op, except out.
// Any opcode/funct pair not listed is flagged as except with all other
// controls forced to their inactive values.
module mips_decode
  import mips_decode_queue_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       rd_src,
  output logic       writeenable,
  output logic [1:0] alu_src2,
  output logic [2:0] alu_op,
  output logic       except
);

  // Control word decode; defaults describe the unsupported-instruction case
  always_comb begin
    rd_src      = 1'b0;
    writeenable = 1'b0;
    alu_src2    = ALU_SRC2_RT;
    alu_op      = ALU_OP_NONE;
    except      = 1'b1;
    case (opcode)
      OP_OTHER0: begin
        case (funct)
          OP0_ADD: alu_op = ALU_OP_ADD;
          OP0_SUB: alu_op = ALU_OP_SUB;
          OP0_AND: alu_op = ALU_OP_AND;
          OP0_OR:  alu_op = ALU_OP_OR;
          OP0_NOR: alu_op = ALU_OP_NOR;
          OP0_XOR: alu_op = ALU_OP_XOR;
          default: alu_op = ALU_OP_NONE;
        endcase
        if (alu_op != ALU_OP_NONE) begin
          writeenable = 1'b1;
          except      = 1'b0;
        end else begin
          except      = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        rd_src      = 1'b1;
        writeenable = 1'b1;
        except      = 1'b0;
        if (opcode == OP_ADDI) begin
          alu_op   = ALU_OP_ADD;
          alu_src2 = ALU_SRC2_SEXT;
        end else if (opcode == OP_ANDI) begin
          alu_op   = ALU_OP_AND;
          alu_src2 = ALU_SRC2_ZEXT;
        end else if (opcode == OP_ORI) begin
          alu_op   = ALU_OP_OR;
          alu_src2 = ALU_SRC2_ZEXT;
        end else begin
          alu_op   = ALU_OP_XOR;
          alu_src2 = ALU_SRC2_ZEXT;
        end
      end
      default: except = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_decode_queue.sv
// Buffered MIPS instruction decoder.
// Ports: clock/reset; in_valid/in_ready/in_inst intake handshake;
// out_valid/out_ready plus decoded head-entry fields (out_*);
// except_clear/halted sticky-halt control; occupancy and except_count status.
// Instructions are decoded on intake and held in a DEPTH-entry FIFO.
// Accepting an unsupported instruction halts intake until except_clear.
module mips_decode_queue
  import mips_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_rd_src,
  output logic                     out_writeenable,
  output logic [1:0]               out_alu_src2,
  output logic [2:0]               out_alu_op,
  output logic                     out_except,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [15:0]              out_imm,
  input  logic                     except_clear,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         except_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  mips_decode u_decode (
    .opcode      (in_inst[31:26]),
    .funct       (in_inst[5:0]),
    .rd_src      (in_entry.rd_src),
    .writeenable (in_entry.writeenable),
    .alu_src2    (in_entry.alu_src2),
    .alu_op      (in_entry.alu_op),
    .except      (in_entry.except)
  );

  assign in_entry.rs  = in_inst[25:21];
  assign in_entry.rt  = in_inst[20:16];
  assign in_entry.rd  = in_inst[15:11];
  assign in_entry.imm = in_inst[15:0];

  // Full is judged on the registered count only, so a pop never frees a slot
  // for a same-cycle push.
  assign in_ready  = !halted && (occupancy < FULL_CNT);
  assign out_valid = (occupancy != {(PTR_W+1){1'b0}});
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry, zeroed while the FIFO is empty
  always_comb begin
    if (out_valid) begin
      head = mem[rd_ptr];
    end else begin
      head = '0;
    end
  end

  assign out_rd_src      = head.rd_src;
  assign out_writeenable = head.writeenable;
  assign out_alu_src2    = head.alu_src2;
  assign out_alu_op      = head.alu_op;
  assign out_except      = head.except;
  assign out_rs          = head.rs;
  assign out_rt          = head.rt;
  assign out_rd          = head.rd;
  assign out_imm         = head.imm;

  // Entry storage; contents need no reset because the head is gated by out_valid
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers, occupancy, sticky halt and saturating except counter
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      halted       <= 1'b0;
      except_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      // Setting by a new except entry takes priority over a clear
      if (push && in_entry.except) begin
        halted <= 1'b1;
      end else if (except_clear) begin
        halted <= 1'b0;
      end
      if (push && in_entry.except && (except_count != CNT_MAX)) begin
        except_count <= except_count + 1'b1;
      end
    end
  end

endmodule
